lcd_hd44780_ctrl: RTL

- Hardware HD44780-compatible character LCD driver, 4-bit bus.
- Sits between the CPU's data-memory write path and the board's lcd_e/lcd_rw/lcd_rs/lcd_db[7:4] pins.
- Replaces software bit-banging of the LCD pins.
- Takes one byte (or one init nibble) per write, generates all bus timing and waits out the execution time.
- Exposes a busy flag the CPU can poll through the IO read mux.

---
 rtl/lcd_hd44780_ctrl_if.sv | 12 +
 rtl/lcd_hd44780_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_ctrl_if.sv
// CPU-side write bus of the HD44780 controller: write strobe, payload and status flags.
interface lcd_hd44780_ctrl_if;
   logic       wr_en;
   logic       wr_rs;
   logic       wr_nib;
   logic [7:0] wr_data;
   logic       busy;
   logic       idle;

   modport master (output wr_en, wr_rs, wr_nib, wr_data, input busy, idle);
   modport slave  (input wr_en, wr_rs, wr_nib, wr_data, output busy, idle);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit bus driver: one byte or init nibble per write, full bus timing and execution wait.
// Define LCD_CTRL_FIFO_EN to put a 4-entry write FIFO in front of the state machine.
module lcd_hd44780_ctrl #(
   parameter int TAS_CYC       = 2,
   parameter int PW_CYC        = 13,
   parameter int TH_CYC        = 2,
   parameter int EXEC_CYC      = 1100,
   parameter int LONG_EXEC_CYC = 41100,
   parameter int CNT_W         = 16
) (
   input  logic               clk,
   input  logic               rst,
   lcd_hd44780_ctrl_if.slave  bus,
   output logic               lcd_e,
   output logic               lcd_rw,
   output logic               lcd_rs,
   output logic [3:0]         lcd_db
);

   typedef enum logic [2:0] {IDLE, SU_H, PW_H, HD_H, SU_L, PW_L, HD_L, WAIT} state_t;

   localparam logic [CNT_W-1:0] TAS_LOAD = CNT_W'(TAS_CYC - 1);
   localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(PW_CYC - 1);
   localparam logic [CNT_W-1:0] TH_LOAD  = CNT_W'(TH_CYC - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             active;
   logic             rs_q;
   logic             nib_q;
   logic [7:0]       data_q;

   logic             start;
   logic             src_rs;
   logic             src_nib;
   logic [7:0]       src_data;

   // Clear Display and Return Home need the long execution wait.
   function automatic logic [CNT_W-1:0] wait_load(input logic rs, input logic nib,
                                                  input logic [7:0] data);
      logic [CNT_W-1:0] load;
      if (!rs && !nib && (data == 8'h01 || data == 8'h02 || data == 8'h03))
         load = CNT_W'(LONG_EXEC_CYC - 1);
      else
         load = CNT_W'(EXEC_CYC - 1);
      return load;
   endfunction

`ifdef LCD_CTRL_FIFO_EN
   logic [9:0] fifo_mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;
   logic       full;
   logic       push;
   logic       pop;

   assign full  = (count == 3'd4);
   assign pop   = (state == IDLE) && (count != 3'd0);
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign push  = bus.wr_en && (!full || pop);
   assign start = pop;
   assign {src_rs, src_nib, src_data} = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {bus.wr_rs, bus.wr_nib, bus.wr_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 2'd1;
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   assign bus.busy = full;
   assign bus.idle = (count == 3'd0) && !active;
`else
   assign start    = (state == IDLE) && bus.wr_en;
   assign src_rs   = bus.wr_rs;
   assign src_nib  = bus.wr_nib;
   assign src_data = bus.wr_data;
   assign bus.busy = active;
   assign bus.idle = !active;
`endif

   always_ff @(posedge clk) begin
      if (start) begin
         rs_q   <= src_rs;
         nib_q  <= src_nib;
         data_q <= src_data;
      end
   end

   assign lcd_rw = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         active <= 1'b0;
         lcd_e  <= 1'b0;
         lcd_rs <= 1'b0;
         lcd_db <= 4'h0;
      end else if (state == IDLE) begin
         if (start) begin
            state  <= SU_H;
            cnt    <= TAS_LOAD;
            active <= 1'b1;
            lcd_rs <= src_rs;
            lcd_db <= src_data[7:4];
         end
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end else begin
         case (state)
            SU_H: begin
               state <= PW_H;
               cnt   <= PW_LOAD;
               lcd_e <= 1'b1;
            end
            PW_H: begin
               state <= HD_H;
               cnt   <= TH_LOAD;
               lcd_e <= 1'b0;
            end
            HD_H: begin
               if (nib_q) begin
                  state <= WAIT;
                  cnt   <= wait_load(rs_q, nib_q, data_q);
               end else begin
                  // Low nibble goes out only after the high-nibble hold time.
                  state  <= SU_L;
                  cnt    <= TAS_LOAD;
                  lcd_db <= data_q[3:0];
               end
            end
            SU_L: begin
               state <= PW_L;
               cnt   <= PW_LOAD;
               lcd_e <= 1'b1;
            end
            PW_L: begin
               state <= HD_L;
               cnt   <= TH_LOAD;
               lcd_e <= 1'b0;
            end
            HD_L: begin
               state <= WAIT;
               cnt   <= wait_load(rs_q, nib_q, data_q);
            end
            WAIT: begin
               state  <= IDLE;
               active <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               active <= 1'b0;
               lcd_e  <= 1'b0;
            end
         endcase
      end
   end

endmodule
